// File: rtl/mem_copy_engine.sv
// Block-copy initiator for a single-port synchronous RAM with one-cycle read latency.
// Optional checksum accumulator and port enabled by defining MEMCOPY_CHECKSUM_EN.
module mem_copy_engine #(
  parameter int bits  = 32,
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [bits-1:0]  src,
  input  logic [bits-1:0]  dst,
  input  logic [bits-1:0]  len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [bits-1:0]  count,
  output logic             mem_writeenable,
  output logic             mem_readenable,
  output logic [bits-1:0]  mem_address,
  output logic [width-1:0] mem_datain,
  input  logic [width-1:0] mem_dataout
`ifdef MEMCOPY_CHECKSUM_EN
  ,
  output logic [width-1:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t          state_reg;
  logic [bits-1:0] src_reg;
  logic [bits-1:0] dst_reg;
  logic [bits-1:0] len_reg;
  logic [bits-1:0] idx_reg;
  logic [bits-1:0] count_reg;
  logic            aborted_reg;
  logic [bits-1:0] idx_next;
  logic            last_word;

  assign idx_next  = idx_reg + bits'(1);
  assign last_word = (idx_next == len_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      src_reg     <= '0;
      dst_reg     <= '0;
      len_reg     <= '0;
      idx_reg     <= '0;
      count_reg   <= '0;
      aborted_reg <= 1'b0;
    end else begin
      aborted_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            src_reg   <= src;
            dst_reg   <= dst;
            len_reg   <= len;
            idx_reg   <= '0;
            count_reg <= '0;
            state_reg <= (len == '0) ? DONE : READ;
          end
        end
        READ: begin
          if (abort) begin
            state_reg   <= IDLE;
            aborted_reg <= 1'b1;
          end else begin
            state_reg <= WRITE;
          end
        end
        WRITE: begin
          // The write in this cycle always lands, even when abort is sampled.
          count_reg <= count_reg + bits'(1);
          if (abort) begin
            state_reg   <= IDLE;
            aborted_reg <= 1'b1;
          end else if (last_word) begin
            state_reg <= DONE;
          end else begin
            idx_reg   <= idx_next;
            state_reg <= READ;
          end
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy            = (state_reg != IDLE);
  assign done            = (state_reg == DONE);
  assign aborted         = aborted_reg;
  assign count           = count_reg;
  assign mem_readenable  = (state_reg == READ);
  assign mem_writeenable = (state_reg == WRITE);

  // Write data is the RAM output register forwarded straight back in.
  assign mem_address = (state_reg == READ)  ? src_reg + idx_reg :
                       (state_reg == WRITE) ? dst_reg + idx_reg : '0;
  assign mem_datain  = (state_reg == WRITE) ? mem_dataout : '0;

`ifdef MEMCOPY_CHECKSUM_EN
  logic [width-1:0] checksum_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      checksum_reg <= '0;
    end else if (state_reg == WRITE) begin
      checksum_reg <= checksum_reg + mem_dataout;
    end
  end

  assign checksum = checksum_reg;
`endif

endmodule
